// File: rtl/noc_pkg.sv
// Shared network-interface definitions: default flit field widths, field
// offsets within a flit and the parity helper used on both TX and RX paths.
// Flit layout, MSB first: {parity, hdr, payload, dest}.
package noc_pkg;

  localparam int ADDR_SZ_DEF = 2;
  localparam int PL_SZ_DEF   = 32;
  localparam int HDR_SZ_DEF  = 3;

  // Widest flit the parity helper accepts; callers zero-extend into it.
  localparam int FLIT_MAX = 256;

  function automatic int dest_lsb();
    return 0;
  endfunction

  function automatic int data_lsb(input int addr_sz);
    return addr_sz;
  endfunction

  function automatic int hdr_lsb(input int addr_sz, input int pl_sz);
    return addr_sz + pl_sz;
  endfunction

  function automatic int parity_pos(input int addr_sz, input int pl_sz, input int hdr_sz);
    return addr_sz + pl_sz + hdr_sz - 1;
  endfunction

  // Zero bits do not change an XOR, so zero-extension is harmless here.
  function automatic logic flit_parity(input logic [FLIT_MAX-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ni_buffered_if.sv
// Host and network signal bundle of the buffered network interface.
// slave  : the network interface itself
// master : the host / network side driving it
interface ni_buffered_if
  import noc_pkg::*;
#(
  parameter int ADDR_SZ = ADDR_SZ_DEF,
  parameter int PL_SZ   = PL_SZ_DEF,
  parameter int HDR_SZ  = HDR_SZ_DEF
);

  localparam int FLIT = HDR_SZ + PL_SZ + ADDR_SZ;

  // Host transmit push side
  logic                tx_valid;
  logic                tx_ready;
  logic [ADDR_SZ-1:0]  tx_dest;
  logic [HDR_SZ-2:0]   tx_hdr;
  logic [PL_SZ-1:0]    tx_data;

  // Network transmit side
  logic [FLIT-1:0]     item_out;
  logic                req;
  logic                channel_busy;

  // Network receive side
  logic [FLIT-1:0]     item_in;
  logic                valid;
  logic                busy;

  // Host receive pop side
  logic                rx_valid;
  logic                rx_ready;
  logic [ADDR_SZ-1:0]  rx_dest;
  logic [HDR_SZ-2:0]   rx_hdr;
  logic [PL_SZ-1:0]    rx_data;

  // Sticky status
  logic                error;
  logic                overflow;

  modport slave (
    input  tx_valid, tx_dest, tx_hdr, tx_data,
    output tx_ready,
    output item_out, req,
    input  channel_busy,
    input  item_in, valid,
    output busy,
    output rx_valid, rx_dest, rx_hdr, rx_data,
    input  rx_ready,
    output error, overflow
  );

  modport master (
    output tx_valid, tx_dest, tx_hdr, tx_data,
    input  tx_ready,
    input  item_out, req,
    output channel_busy,
    output item_in, valid,
    input  busy,
    input  rx_valid, rx_dest, rx_hdr, rx_data,
    output rx_ready,
    input  error, overflow
  );

endinterface

// File: rtl/ni_fifo.sv
// Synchronous FIFO used for both the TX and RX buffers of the network
// interface. DEPTH must be a power of two so the pointers wrap for free.
// FWFT=1 presents the head word combinationally; FWFT=0 registers it on pop.
// Push when full and pop when empty are ignored.
module ni_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter bit FWFT  = 1'b1,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;

  // Next pointer and occupancy values; push and pop together keep count.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    count_d = count_q + CW'(doPush) - CW'(doPop);
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= wdata_i;
  end

  if (FWFT) begin : g_fwft
    assign rdata_o = mem[rdPtr_q];
  end else begin : g_regread
    logic [WIDTH-1:0] rdata_q;

    // Registered read port loaded with the word leaving on each pop.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)      rdata_q <= '0;
      else if (doPop) rdata_q <= mem[rdPtr_q];
    end

    assign rdata_o = rdata_q;
  end

endmodule

// File: rtl/ni_buffered.sv
// Buffered network interface: a TX FIFO feeding a registered flit output
// with a one-cycle req strobe, and an RX FIFO the host drains with a
// first-word-fall-through handshake. Sticky error/overflow status.
// Optional build macro NI_PARITY_CHECK_EN: RX flits with a parity mismatch
// are discarded and raise error. Without it every RX flit that finds room
// is stored and error stays low. TX parity is always generated.
module ni_buffered
  import noc_pkg::*;
#(
  parameter int ID       = 0,
  parameter int ADDR_SZ  = ADDR_SZ_DEF,
  parameter int PL_SZ    = PL_SZ_DEF,
  parameter int HDR_SZ   = HDR_SZ_DEF,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  ni_buffered_if.slave bus
);

  localparam int FLIT     = HDR_SZ + PL_SZ + ADDR_SZ;
  localparam int LOW      = FLIT - 1;
  localparam int DEST_LSB = dest_lsb();
  localparam int DATA_LSB = data_lsb(ADDR_SZ);
  localparam int HDR_LSB  = hdr_lsb(ADDR_SZ, PL_SZ);
  localparam int PAR_POS  = parity_pos(ADDR_SZ, PL_SZ, HDR_SZ);
  localparam int TX_CW    = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW    = $clog2(RX_DEPTH) + 1;
  localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
  localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);

  // TX path
  logic [LOW-1:0]   txLow;
  logic [FLIT-1:0]  txFlit;
  logic [FLIT-1:0]  txHead;
  logic             txPush, txPop, txFull, txEmpty;
  logic [TX_CW-1:0] txCount;
  logic [FLIT-1:0]  itemOut_q, itemOut_d;
  logic             req_q, req_d;

  // RX path
  logic [LOW-1:0]   rxHead;
  logic             rxPush, rxPop, rxFull, rxEmpty, rxBusy, rxParityOk;
  logic [RX_CW-1:0] rxCount;
  logic             overflow_q, overflow_d;

  assign txLow   = {bus.tx_hdr, bus.tx_data, bus.tx_dest};
  assign txPush  = bus.tx_valid & ~txFull;
  assign txPop   = ~txEmpty & ~bus.channel_busy;
  assign bus.tx_ready = ~txFull;

  // Assemble the outgoing flit and stamp its parity over the lower bits.
  always_comb begin
    txFlit          = '0;
    txFlit[LOW-1:0] = txLow;
    txFlit[PAR_POS] = flit_parity(FLIT_MAX'(txLow));
  end

  ni_fifo #(
    .WIDTH (FLIT),
    .DEPTH (TX_DEPTH),
    .FWFT  (1'b1)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (txPush),
    .wdata_i (txFlit),
    .pop_i   (txPop),
    .rdata_o (txHead),
    .full_o  (txFull),
    .empty_o (txEmpty),
    .count_o (txCount)
  );

  // Load the head flit into the output register whenever the channel is free.
  always_comb begin
    itemOut_d = itemOut_q;
    req_d     = 1'b0;
    if (txPop) begin
      itemOut_d = txHead;
      req_d     = 1'b1;
    end
  end

  // Output flit register and its one-cycle strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      itemOut_q <= '0;
      req_q     <= 1'b0;
    end else begin
      itemOut_q <= itemOut_d;
      req_q     <= req_d;
    end
  end

  assign bus.item_out = itemOut_q;
  assign bus.req      = req_q;

  // Busy comes straight from the registered occupancy so the network sees
  // a glitch-free hold-off; a flit arriving while busy is lost even if the
  // host pops on the same edge.
  assign rxBusy   = (rxCount == RX_FULL_CNT);
  assign rxPush   = bus.valid & ~rxBusy & rxParityOk;
  assign rxPop    = bus.rx_ready & ~rxEmpty;
  assign bus.busy = rxBusy;

  ni_fifo #(
    .WIDTH (LOW),
    .DEPTH (RX_DEPTH),
    .FWFT  (1'b1)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rxPush),
    .wdata_i (bus.item_in[LOW-1:0]),
    .pop_i   (rxPop),
    .rdata_o (rxHead),
    .full_o  (rxFull),
    .empty_o (rxEmpty),
    .count_o (rxCount)
  );

  assign bus.rx_valid = ~rxEmpty;
  assign bus.rx_dest  = rxHead[DEST_LSB +: ADDR_SZ];
  assign bus.rx_data  = rxHead[DATA_LSB +: PL_SZ];
  assign bus.rx_hdr   = rxHead[HDR_LSB +: HDR_SZ-1];

  // Overflow latches on any flit that arrives while the RX FIFO is full.
  always_comb begin
    overflow_d = overflow_q | (bus.valid & rxBusy);
  end

  // Sticky overflow register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign bus.overflow = overflow_q;

`ifdef NI_PARITY_CHECK_EN
  logic error_q, error_d;

  assign rxParityOk = (flit_parity(FLIT_MAX'(bus.item_in[LOW-1:0])) == bus.item_in[PAR_POS]);

  // Error latches when a flit that would otherwise be stored fails parity.
  always_comb begin
    error_d = error_q | (bus.valid & ~rxBusy & ~rxParityOk);
  end

  // Sticky parity error register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= error_d;
  end

  assign bus.error = error_q;
`else
  assign rxParityOk = 1'b1;
  assign bus.error  = 1'b0;
`endif

  // The FIFO full flags must always agree with their occupancy counts.
  assert property (@(posedge clk) disable iff (reset)
                   (txFull == (txCount == TX_FULL_CNT)) && (rxFull == rxBusy))
    else $error("ni_buffered node %0d: FIFO full flag disagrees with count", ID);

endmodule

// File: tb/tb_ni_buffered.sv
// Scoreboard bench for ni_buffered (ADDR_SZ=2, PL_SZ=8, HDR_SZ=3, depth 4).
// Stimulus pushes expected flits into queues; a negedge monitor pops and
// compares whenever the DUT strobes req or the host pops RX.
module tb_ni_buffered;

  localparam int ADDR_SZ = 2;
  localparam int PL_SZ   = 8;
  localparam int HDR_SZ  = 3;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic reset;

  int compared   = 0;
  int mismatched = 0;

  logic [12:0] txExp[$];
  logic [11:0] rxExp[$];

  ni_buffered_if #(.ADDR_SZ(ADDR_SZ), .PL_SZ(PL_SZ), .HDR_SZ(HDR_SZ)) bus ();

  ni_buffered #(
    .ID       (3),
    .ADDR_SZ  (ADDR_SZ),
    .PL_SZ    (PL_SZ),
    .HDR_SZ   (HDR_SZ),
    .TX_DEPTH (DEPTH),
    .RX_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference flit builder: parity is the XOR of the twelve lower bits.
  function automatic logic [12:0] makeFlit(input logic [1:0] dest, input logic [1:0] hdr,
                                           input logic [7:0] data);
    logic [11:0] low;
    low = {hdr, data, dest};
    return {^low, low};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Advance the given number of rising edges, landing 1 time unit after.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushTx(input logic [1:0] dest, input logic [1:0] hdr, input logic [7:0] data,
                        input bit expectOut, input logic [12:0] expFlit);
    bus.tx_valid = 1'b1;
    bus.tx_dest  = dest;
    bus.tx_hdr   = hdr;
    bus.tx_data  = data;
    if (expectOut) txExp.push_back(expFlit);
    applyStimulus(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic sendRx(input logic [12:0] flit, input bit expectStored);
    bus.valid   = 1'b1;
    bus.item_in = flit;
    if (expectStored) rxExp.push_back(flit[11:0]);
    applyStimulus(1);
    bus.valid = 1'b0;
  endtask

  // Monitor: compare each req strobe and each RX pop against the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.req) begin
      if (txExp.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL tx_unexpected: got item_out %0h, expected no req", bus.item_out);
      end else begin
        checkOutput("tx_item_out", 32'(bus.item_out), 32'(txExp.pop_front()));
      end
    end
    if (!reset && bus.rx_valid && bus.rx_ready) begin
      if (rxExp.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL rx_unexpected: got rx head %0h, expected empty",
                 {bus.rx_hdr, bus.rx_data, bus.rx_dest});
      end else begin
        checkOutput("rx_head", 32'({bus.rx_hdr, bus.rx_data, bus.rx_dest}),
                    32'(rxExp.pop_front()));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    bus.tx_valid     = 1'b0;
    bus.tx_dest      = '0;
    bus.tx_hdr       = '0;
    bus.tx_data      = '0;
    bus.channel_busy = 1'b0;
    bus.item_in      = '0;
    bus.valid        = 1'b0;
    bus.rx_ready     = 1'b0;

    // Reset values before any clock edge
    #2;
    checkOutput("rst_req",      32'(bus.req),      0);
    checkOutput("rst_item_out", 32'(bus.item_out), 0);
    checkOutput("rst_tx_ready", 32'(bus.tx_ready), 1);
    checkOutput("rst_busy",     32'(bus.busy),     0);
    checkOutput("rst_rx_valid", 32'(bus.rx_valid), 0);
    checkOutput("rst_error",    32'(bus.error),    0);
    checkOutput("rst_overflow", 32'(bus.overflow), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single flit, hand-computed 13'h0695, req one cycle after the push edge
    pushTx(2'd1, 2'b01, 8'hA5, 1'b1, 13'h0695);
    checkOutput("tx_req_not_on_push_edge", 32'(bus.req), 0);
    applyStimulus(1);
    checkOutput("tx_req_pulse", 32'(bus.req), 1);
    applyStimulus(1);
    checkOutput("tx_req_one_cycle", 32'(bus.req), 0);

    // Fill TX while the channel is busy, then release for back-to-back req
    bus.channel_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pushTx(2'(i), 2'(3 - i), 8'(8'h10 + i), 1'b1,
             makeFlit(2'(i), 2'(3 - i), 8'(8'h10 + i)));
      checkOutput("tx_no_req_while_busy", 32'(bus.req), 0);
    end
    checkOutput("tx_ready_full", 32'(bus.tx_ready), 0);
    pushTx(2'd3, 2'd3, 8'hEE, 1'b0, '0);
    checkOutput("tx_ready_still_full", 32'(bus.tx_ready), 0);
    bus.channel_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("tx_req_consecutive", 32'(bus.req), 1);
    end
    applyStimulus(1);
    checkOutput("tx_req_done", 32'(bus.req), 0);
    checkOutput("tx_ready_empty", 32'(bus.tx_ready), 1);

    // Fill RX with the host stalled; fifth flit is dropped
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sendRx(makeFlit(2'(i), 2'(i + 1), 8'(8'h30 + i)), i < 4);
      if (i == 2) checkOutput("rx_busy_three", 32'(bus.busy), 0);
      if (i == 3) begin
        checkOutput("rx_busy_four", 32'(bus.busy), 1);
        checkOutput("rx_no_overflow_yet", 32'(bus.overflow), 0);
      end
    end
    checkOutput("rx_overflow", 32'(bus.overflow), 1);
    bus.rx_ready = 1'b1;
    applyStimulus(4);
    bus.rx_ready = 1'b0;
    checkOutput("rx_drained", 32'(bus.rx_valid), 0);
    checkOutput("rx_busy_drained", 32'(bus.busy), 0);

    // Bad-parity flit 13'h1695
`ifdef NI_PARITY_CHECK_EN
    sendRx(13'h1695, 1'b0);
    checkOutput("par_error_set", 32'(bus.error), 1);
    checkOutput("par_not_stored", 32'(bus.rx_valid), 0);
`else
    sendRx(13'h1695, 1'b1);
    checkOutput("par_error_clear", 32'(bus.error), 0);
    checkOutput("par_stored", 32'(bus.rx_valid), 1);
    bus.rx_ready = 1'b1;
    applyStimulus(1);
    bus.rx_ready = 1'b0;
`endif

    // Two flits in each FIFO, then an asynchronous reset pulse between edges
    bus.channel_busy = 1'b1;
    pushTx(2'd2, 2'd1, 8'h55, 1'b0, '0);
    pushTx(2'd1, 2'd2, 8'h66, 1'b0, '0);
    sendRx(makeFlit(2'd0, 2'd1, 8'h77), 1'b0);
    sendRx(makeFlit(2'd3, 2'd0, 8'h88), 1'b0);
    checkOutput("pre_rst_rx_valid", 32'(bus.rx_valid), 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_rst_req",      32'(bus.req),      0);
    checkOutput("mid_rst_rx_valid", 32'(bus.rx_valid), 0);
    checkOutput("mid_rst_tx_ready", 32'(bus.tx_ready), 1);
    checkOutput("mid_rst_busy",     32'(bus.busy),     0);
    checkOutput("mid_rst_error",    32'(bus.error),    0);
    checkOutput("mid_rst_overflow", 32'(bus.overflow), 0);
    #1 reset = 1'b0;
    bus.channel_busy = 1'b0;
    applyStimulus(2);
    checkOutput("post_rst_req",      32'(bus.req),      0);
    checkOutput("post_rst_rx_valid", 32'(bus.rx_valid), 0);

    // RX full with an arriving flit and a host pop on the same edge
    for (int i = 0; i < 4; i++) begin
      sendRx(makeFlit(2'(3 - i), 2'(i), 8'(8'hC0 + i)), 1'b1);
    end
    checkOutput("full_busy", 32'(bus.busy), 1);
    checkOutput("full_no_overflow", 32'(bus.overflow), 0);
    bus.valid    = 1'b1;
    bus.item_in  = makeFlit(2'd2, 2'd2, 8'hDD);
    bus.rx_ready = 1'b1;
    applyStimulus(1);
    bus.valid = 1'b0;
    checkOutput("simul_overflow", 32'(bus.overflow), 1);
    checkOutput("simul_busy_count3", 32'(bus.busy), 0);
    checkOutput("simul_rx_valid", 32'(bus.rx_valid), 1);
    applyStimulus(3);
    bus.rx_ready = 1'b0;
    checkOutput("simul_drained", 32'(bus.rx_valid), 0);

    applyStimulus(2);
    checkOutput("tx_scoreboard_empty", 32'(txExp.size()), 0);
    checkOutput("rx_scoreboard_empty", 32'(rxExp.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ni_buffered.md
NI_BUFFERED -- requirements
Module: ni_buffered

Interface
REQ-001 Parameter ID, default 0: node address; informational; not used in datapath.
REQ-002 Parameter ADDR_SZ, default 2; PL_SZ, default 32; HDR_SZ, default 3 (MSB is parity); FLIT = HDR_SZ+PL_SZ+ADDR_SZ.
REQ-003 Parameter TX_DEPTH, default 4; RX_DEPTH, default 4; power of two, >=2.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 tx_valid/tx_ready  in/out  1/1  host push handshake.
REQ-007 tx_dest, tx_hdr, tx_data  in  ADDR_SZ, HDR_SZ-1, PL_SZ  host flit fields.
REQ-008 item_out  out  FLIT  {parity, hdr, payload, dest}, registered.
REQ-009 req  out  1  one-cycle strobe: item_out valid.
REQ-010 channel_busy  in  1  network cannot accept this cycle.
REQ-011 item_in  in  FLIT  incoming flit, same layout; valid  in  1  qualifier.
REQ-012 busy  out  1  RX FIFO full; network holds off.
REQ-013 rx_valid/rx_ready  out/in  1/1  host pop handshake, first-word-fall-through.
REQ-014 rx_dest, rx_hdr, rx_data  out  ADDR_SZ, HDR_SZ-1, PL_SZ  RX head fields.
REQ-015 error  out  1  sticky parity error; overflow  out  1  sticky RX drop.

Function
REQ-016 tx_ready = TX FIFO not full; push on edge with tx_valid & tx_ready; push when full ignored.
REQ-017 Parity = XOR of the FLIT-1 low bits; generated at push, stored in FIFO.
REQ-018 Each edge with TX FIFO non-empty and channel_busy low: item_out <= head, req <= 1, pop; else req <= 0, item_out holds.
REQ-019 Latency: flit pushed on edge E presents req=1 after edge E+1 at earliest; back-to-back flits give req on consecutive cycles.
REQ-020 busy = RX count == RX_DEPTH, from registered state.
REQ-021 Edge with valid & !busy & flit accepted: write to RX FIFO; valid & busy: flit dropped, overflow <= 1, even if rx pop occurs same edge.
REQ-022 rx_valid = RX FIFO non-empty; pop on rx_valid & rx_ready; rx_* show head; don't-care when empty.
REQ-023 Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, order preserved.
REQ-024 TX and RX paths independent; loopback allowed only via external wiring.
REQ-025 error, overflow set-only; cleared only by reset.

Reset
REQ-026 reset high: item_out=0, req=0, error=0, overflow=0, both FIFOs empty (tx_ready=1, busy=0, rx_valid=0) immediately, without clock.
REQ-027 Reset mid-operation discards all buffered flits; first edge after deassertion behaves as post-reset idle.

Configuration
REQ-028 Macro NI_PARITY_CHECK_EN defined: RX flit with parity mismatch not stored, error <= 1 next edge.
REQ-029 Macro undefined: no RX parity check; all non-dropped flits stored; error tied 0; TX parity still generated.

Structure
REQ-030 Shared package noc_pkg: flit field widths defaults, flit field offsets, parity function.
REQ-031 Sub-module ni_fifo (parametrised WIDTH, DEPTH, FWFT, full/empty/count) instantiated twice.
REQ-032 Output register and strobe logic in ni_buffered top, not in ni_fifo.

Verification (ADDR_SZ=2, PL_SZ=8, HDR_SZ=3)
REQ-033 Push dest=1, hdr=2'b01, data=8'hA5, channel_busy=0 -> after next edge req=1 one cycle, item_out=13'h0695.
REQ-034 channel_busy=1, push 4 flits -> tx_ready=0 after 4th, no req; drop channel_busy -> 4 req pulses on consecutive cycles, order kept.
REQ-035 rx_ready=0, 5 valid flits -> busy=1 after 4th, 5th dropped, overflow=1; drain returns first 4 in order.
REQ-036 Flit 13'h1695 (bad parity) -> with NI_PARITY_CHECK_EN: error=1, rx_valid stays 0; without: stored, error=0.
REQ-037 2 flits in each FIFO, pulse reset between edges -> req=0, rx_valid=0, tx_ready=1, busy=0, error=0 at once.
REQ-038 RX full, valid=1 and rx_ready=1 same edge -> one flit popped, incoming dropped, overflow=1, count 3.
